bp_cfg_boot_sequencer: RTL and testbench

// Post-reset configuration sequencer between the processor-parameter configuration and the core tiles.
// For every core, in order, it issues config-bus register writes: freeze, core id, CCE mode and start PC.
// It then releases freeze on all cores.

---
 rtl/bp_cfg_boot_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_bp_cfg_boot_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_boot_sequencer.sv
// bp_cfg_boot_sequencer
//   Post-reset configuration sequencer. For each core in turn it writes
//   FREEZE=1, CORE_ID, CCE_MODE and NPC over a valid/ready config command
//   port, then writes FREEZE=0 to every core, waits for all writes to be
//   acknowledged and reports done. A credit counter limits the number of
//   unacknowledged writes in flight.
//
// Ports
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   start_i            start pulse, honoured only when idle or done
//   npc_i, cce_mode_i  start PC and CCE mode, captured on an accepted start
//   cmd_v_o/cmd_ready_i/cmd_addr_o/cmd_data_o   config write command
//   ack_v_i            one write acknowledged
//   busy_o, done_o     sequence running / sequence complete and fully acked
//   err_o              sticky: ack seen with nothing outstanding
module bp_cfg_boot_sequencer #(
    parameter int num_core_p       = 2,
    parameter int vaddr_width_p    = 39,
    parameter int cfg_addr_width_p = 20,
    parameter int cfg_data_width_p = 64,
    parameter int max_credits_p    = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    input  logic [vaddr_width_p-1:0]    npc_i,
    input  logic                        cce_mode_i,
    output logic                        cmd_v_o,
    input  logic                        cmd_ready_i,
    output logic [cfg_addr_width_p-1:0] cmd_addr_o,
    output logic [cfg_data_width_p-1:0] cmd_data_o,
    input  logic                        ack_v_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int credit_width_lp  = $clog2(max_credits_p + 1);
    localparam int idx_pad_lp       = cfg_addr_width_p - 16;

    localparam logic [core_id_width_lp-1:0] last_core_lp   = core_id_width_lp'(num_core_p - 1);
    localparam logic [core_id_width_lp-1:0] core_one_lp    = core_id_width_lp'(1);
    localparam logic [credit_width_lp-1:0]  max_credits_lp = credit_width_lp'(max_credits_p);
    localparam logic [credit_width_lp-1:0]  credit_one_lp  = credit_width_lp'(1);

    localparam logic [15:0] off_freeze_lp   = 16'h0008;
    localparam logic [15:0] off_core_id_lp  = 16'h0010;
    localparam logic [15:0] off_cce_mode_lp = 16'h0018;
    localparam logic [15:0] off_npc_lp      = 16'h0020;

    // The "next core" decision is taken on the NPC handshake itself, so it
    // costs no cycle and needs no state of its own.
    typedef enum logic [3:0] {
        IDLE, FREEZE, CORE_ID, CCE_MODE, NPC, UNFREEZE, DRAIN, DONE
    } state_e;

    state_e                      state_r, state_n;
    logic [core_id_width_lp-1:0] core_idx_r, core_idx_n;
    logic [credit_width_lp-1:0]  credits_r, credits_n;
    logic                        err_r;
    logic                        ack_underflow;
    logic [vaddr_width_p-1:0]    npc_r;
    logic                        cce_mode_r;
    logic                        hs;
    logic                        start_ok;
    logic                        last_core;

    assign hs        = cmd_v_o & cmd_ready_i;
    assign start_ok  = start_i & ((state_r == IDLE) | (state_r == DONE));
    assign last_core = (core_idx_r == last_core_lp);

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            core_idx_r <= '0;
            credits_r  <= '0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            core_idx_r <= core_idx_n;
            credits_r  <= credits_n;
            err_r      <= err_r | ack_underflow;
        end
    end

    // Sequence parameters are plain data: captured on start, never reset.
    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            npc_r      <= npc_i;
            cce_mode_r <= cce_mode_i;
        end
    end

    // Credit accounting. A handshake and an ack in the same cycle cancel,
    // including at zero outstanding (the ack covers the write just issued).
    always_comb begin
        credits_n     = credits_r;
        ack_underflow = 1'b0;
        if (hs && !ack_v_i) begin
            credits_n = credits_r + credit_one_lp;
        end else if (!hs && ack_v_i) begin
            if (credits_r == '0) begin
                ack_underflow = 1'b1;
            end else begin
                credits_n = credits_r - credit_one_lp;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_n    = state_r;
        core_idx_n = core_idx_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    state_n    = FREEZE;
                    core_idx_n = '0;
                end
            end
            FREEZE:   if (hs) state_n = CORE_ID;
            CORE_ID:  if (hs) state_n = CCE_MODE;
            CCE_MODE: if (hs) state_n = NPC;
            NPC: begin
                if (hs) begin
                    if (last_core) begin
                        core_idx_n = '0;
                        state_n    = UNFREEZE;
                    end else begin
                        core_idx_n = core_idx_r + core_one_lp;
                        state_n    = FREEZE;
                    end
                end
            end
            UNFREEZE: begin
                if (hs) begin
                    if (last_core) begin
                        core_idx_n = '0;
                        state_n    = DRAIN;
                    end else begin
                        core_idx_n = core_idx_r + core_one_lp;
                    end
                end
            end
            // Looking at the post-ack count lets the final ack and the move
            // to DONE share a cycle.
            DRAIN:    if (credits_n == '0) state_n = DONE;
            default:  state_n = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_v_o    = 1'b0;
        cmd_addr_o = '0;
        cmd_data_o = '0;
        case (state_r)
            FREEZE: begin
                cmd_addr_o = {idx_pad_lp'(core_idx_r), off_freeze_lp};
                cmd_data_o = cfg_data_width_p'(1);
            end
            CORE_ID: begin
                cmd_addr_o = {idx_pad_lp'(core_idx_r), off_core_id_lp};
                cmd_data_o = cfg_data_width_p'(core_idx_r);
            end
            CCE_MODE: begin
                cmd_addr_o = {idx_pad_lp'(core_idx_r), off_cce_mode_lp};
                cmd_data_o = cfg_data_width_p'(cce_mode_r);
            end
            NPC: begin
                cmd_addr_o = {idx_pad_lp'(core_idx_r), off_npc_lp};
                cmd_data_o = cfg_data_width_p'(npc_r);
            end
            UNFREEZE: begin
                cmd_addr_o = {idx_pad_lp'(core_idx_r), off_freeze_lp};
                cmd_data_o = '0;
            end
            default: begin
                cmd_addr_o = '0;
                cmd_data_o = '0;
            end
        endcase
        if ((state_r == FREEZE) || (state_r == CORE_ID) || (state_r == CCE_MODE) ||
            (state_r == NPC) || (state_r == UNFREEZE)) begin
            cmd_v_o = (credits_r < max_credits_lp);
        end
    end

    assign busy_o = (state_r != IDLE) && (state_r != DONE);
    assign done_o = (state_r == DONE);
    assign err_o  = err_r;

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Directed bench for bp_cfg_boot_sequencer (2 cores, 4 credits).
module tb_bp_cfg_boot_sequencer;

    localparam int AW = 20;
    localparam int DW = 64;
    localparam int VW = 39;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          start_i;
    logic [VW-1:0] npc_i;
    logic          cce_mode_i;
    logic          cmd_v_o;
    logic          cmd_ready_i;
    logic [AW-1:0] cmd_addr_o;
    logic [DW-1:0] cmd_data_o;
    logic          ack_v_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    bp_cfg_boot_sequencer #(
        .num_core_p      (2),
        .vaddr_width_p   (VW),
        .cfg_addr_width_p(AW),
        .cfg_data_width_p(DW),
        .max_credits_p   (4)
    ) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .start_i    (start_i),
        .npc_i      (npc_i),
        .cce_mode_i (cce_mode_i),
        .cmd_v_o    (cmd_v_o),
        .cmd_ready_i(cmd_ready_i),
        .cmd_addr_o (cmd_addr_o),
        .cmd_data_o (cmd_data_o),
        .ack_v_i    (ack_v_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    int            errors = 0;
    int            checks = 0;
    logic          auto_ack = 1'b0;
    logic          stab_en = 1'b0;
    logic          last_hs = 1'b0;
    logic          prev_pend = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            n;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Write capture and hold-stability watch, sampled at the clock edge.
    always @(posedge clk_i) begin
        if (reset_n_i && stab_en && prev_pend) begin
            chk("hold_v", 64'(cmd_v_o), 64'd1);
            chk("hold_addr", 64'(cmd_addr_o), 64'(prev_addr));
            chk("hold_data", cmd_data_o, prev_data);
        end
        prev_pend = reset_n_i && cmd_v_o && !cmd_ready_i;
        prev_addr = cmd_addr_o;
        prev_data = cmd_data_o;
        last_hs   = reset_n_i && cmd_v_o && cmd_ready_i;
        if (last_hs) begin
            wr_addr_q.push_back(cmd_addr_o);
            wr_data_q.push_back(cmd_data_o);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (auto_ack) ack_v_i = last_hs;
    endtask

    task automatic pulse_start(input logic [VW-1:0] npc, input logic mode);
        start_i    = 1'b1;
        npc_i      = npc;
        cce_mode_i = mode;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, output int cyc);
        cyc = 0;
        while (!done_o && cyc < 300) begin
            if (rnd) cmd_ready_i = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        cmd_ready_i = 1'b1;
        chk("done", 64'(done_o), 64'd1);
    endtask

    task automatic wait_off(input logic [15:0] off);
        int k = 0;
        while (!(cmd_v_o && cmd_addr_o[15:0] == off) && k < 60) begin
            tick();
            k++;
        end
        chk("reach_offset", 64'(k < 60), 64'd1);
    endtask

    function automatic logic [AW-1:0] exp_addr(input int i);
        int          core;
        logic [15:0] off;
        if (i < 8) begin
            core = i / 4;
            case (i % 4)
                0:       off = 16'h0008;
                1:       off = 16'h0010;
                2:       off = 16'h0018;
                default: off = 16'h0020;
            endcase
        end else begin
            core = i - 8;
            off  = 16'h0008;
        end
        return {core[3:0], off};
    endfunction

    function automatic logic [DW-1:0] exp_data(input int i, input logic [VW-1:0] npc, input logic mode);
        if (i >= 8) return 64'd0;
        case (i % 4)
            0:       return 64'd1;
            1:       return 64'(i / 4);
            2:       return 64'(mode);
            default: return 64'(npc);
        endcase
    endfunction

    task automatic check_writes(input logic [VW-1:0] npc, input logic mode);
        chk("num_writes", 64'(wr_addr_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < wr_addr_q.size()) begin
                chk($sformatf("wr%0d_addr", i), 64'(wr_addr_q[i]), 64'(exp_addr(i)));
                chk($sformatf("wr%0d_data", i), wr_data_q[i], exp_data(i, npc, mode));
            end
        end
    endtask

    task automatic clear_q();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n_i   = 1'b0;
        start_i     = 1'b0;
        npc_i       = '0;
        cce_mode_i  = 1'b0;
        cmd_ready_i = 1'b1;
        ack_v_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cmd_v", 64'(cmd_v_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_addr", 64'(cmd_addr_o), 64'd0);
        chk("rst_data", cmd_data_o, 64'd0);
        reset_n_i = 1'b1;
        tick();

        // Full sequence, ready always high, immediate acks
        auto_ack = 1'b1;
        clear_q();
        pulse_start(39'h80000000, 1'b1);
        chk("s1_busy", 64'(busy_o), 64'd1);
        chk("s1_done_low", 64'(done_o), 64'd0);
        wait_done(1'b0, n);
        chk("s1_latency", 64'(n), 64'd11);
        check_writes(39'h80000000, 1'b1);
        chk("s1_busy_end", 64'(busy_o), 64'd0);
        chk("s1_err", 64'(err_o), 64'd0);

        // Random ready, write stream must be unchanged
        clear_q();
        stab_en = 1'b1;
        pulse_start(39'h80000000, 1'b1);
        wait_done(1'b1, n);
        stab_en = 1'b0;
        check_writes(39'h80000000, 1'b1);

        // Acks withheld: credit limit
        auto_ack = 1'b0;
        ack_v_i  = 1'b0;
        clear_q();
        pulse_start(39'h80000000, 1'b1);
        repeat (8) tick();
        chk("credit_stall_count", 64'(wr_addr_q.size()), 64'd4);
        chk("credit_stall_v", 64'(cmd_v_o), 64'd0);
        ack_v_i = 1'b1;
        tick();
        ack_v_i = 1'b0;
        repeat (4) tick();
        chk("one_ack_one_write", 64'(wr_addr_q.size()), 64'd5);
        chk("one_ack_stall_v", 64'(cmd_v_o), 64'd0);

        // Ack and handshake together keep the count; no overflow past 4
        ack_v_i = 1'b1;
        tick();
        chk("v_after_ack", 64'(cmd_v_o), 64'd1);
        tick();
        ack_v_i = 1'b0;
        chk("v_after_hs_ack", 64'(cmd_v_o), 64'd1);
        chk("hs_ack_count", 64'(wr_addr_q.size()), 64'd6);
        repeat (4) tick();
        chk("no_overflow_count", 64'(wr_addr_q.size()), 64'd7);
        chk("no_overflow_v", 64'(cmd_v_o), 64'd0);
        if (wr_addr_q.size() > 6) begin
            chk("wr6_addr", 64'(wr_addr_q[6]), 64'h10018);
            chk("wr6_data", wr_data_q[6], 64'd1);
        end

        // Ack with nothing outstanding sets the sticky error
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        tick();
        chk("idle_after_rst", 64'(busy_o), 64'd0);
        chk("err_clear", 64'(err_o), 64'd0);
        ack_v_i = 1'b1;
        tick();
        ack_v_i = 1'b0;
        tick();
        chk("err_set", 64'(err_o), 64'd1);
        repeat (3) tick();
        chk("err_sticky", 64'(err_o), 64'd1);

        // Start during CCE_MODE ignored; restart from DONE with new data
        auto_ack = 1'b1;
        clear_q();
        pulse_start(39'h80000000, 1'b1);
        wait_off(16'h0018);
        start_i    = 1'b1;
        npc_i      = 39'h1000;
        cce_mode_i = 1'b0;
        tick();
        start_i = 1'b0;
        wait_done(1'b0, n);
        check_writes(39'h80000000, 1'b1);
        chk("err_still_set", 64'(err_o), 64'd1);
        clear_q();
        pulse_start(39'h1000, 1'b0);
        wait_done(1'b0, n);
        chk("restart_latency", 64'(n), 64'd11);
        check_writes(39'h1000, 1'b0);

        // Reset during NPC write: outputs drop immediately
        clear_q();
        pulse_start(39'h80000000, 1'b1);
        wait_off(16'h0020);
        reset_n_i = 1'b0;
        #1;
        chk("midrst_cmd_v", 64'(cmd_v_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        chk("midrst_addr", 64'(cmd_addr_o), 64'd0);
        chk("midrst_data", cmd_data_o, 64'd0);
        chk("midrst_err", 64'(err_o), 64'd0);
        tick();
        reset_n_i = 1'b1;
        tick();
        clear_q();
        pulse_start(39'h2000, 1'b0);
        wait_done(1'b0, n);
        chk("post_rst_latency", 64'(n), 64'd11);
        check_writes(39'h2000, 1'b0);
        chk("post_rst_err", 64'(err_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
